// File: rtl/i2s_mic_rx_if.sv
// i2s_mic_rx_if: I2S microphone pins plus the PCM valid/ready output bundle
interface i2s_mic_rx_if #(
  parameter int DATA_W = 24
);
  logic i2s_sd;
  logic i2s_bclk;
  logic i2s_ws;
  logic [DATA_W-1:0] pcm_l;
  logic [DATA_W-1:0] pcm_r;
  logic pcm_valid;
  logic pcm_ready;
  logic overrun;
  modport master (
    input  i2s_sd, pcm_ready,
    output i2s_bclk, i2s_ws, pcm_l, pcm_r, pcm_valid, overrun
  );
  modport slave (
    output i2s_sd, pcm_ready,
    input  i2s_bclk, i2s_ws, pcm_l, pcm_r, pcm_valid, overrun
  );
endinterface

// File: rtl/i2s_mic_rx.sv
// i2s_mic_rx: I2S master receiver for a MEMS mic (DATA_W bits in 32-bit slots, 64 BCLK/frame).
// Define MIC_MONO_EN to capture the left slot only, with pcm_r held at 0.
module i2s_mic_rx #(
  parameter int BCLK_DIV = 16,
  parameter int DATA_W = 24,
  parameter int SETTLE_FRAMES = 2
) (
  input logic clk,
  input logic rst,
  input logic en,
  i2s_mic_rx_if.master bus
);
`ifdef MIC_MONO_EN
  localparam bit MONO = 1'b1;
`else
  localparam bit MONO = 1'b0;
`endif
  localparam int DW = $clog2(BCLK_DIV);
  localparam int FW = $clog2(SETTLE_FRAMES + 2);
  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;
  state_t state;
  state_t state_n;
  logic [DW-1:0] div_cnt;
  logic [5:0] bit_cnt;
  logic [5:0] bit_nx;
  logic [4:0] p;
  logic [FW-1:0] frame_cnt;
  logic bclk;
  logic ws;
  logic tick;
  logic rise;
  logic fall;
  logic wrap;
  logic clr;
  logic cap;
  logic last;
  logic pend;
  logic valid;
  logic ovr;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] left_hold;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] pcm_l;
  logic [DATA_W-1:0] pcm_r;
  always_comb begin
    tick = div_cnt == DW'(BCLK_DIV - 1);
    rise = tick && !bclk;
    fall = tick && bclk;
    bit_nx = bit_cnt + 6'd1;
    wrap = fall && bit_cnt == 6'd63;
    p = bit_cnt[4:0];
    shifted = DATA_W'({shift_reg, bus.i2s_sd});
    cap = rise && p != 5'd0 && int'(p) <= DATA_W && !(MONO && bit_cnt[5]);
    last = rise && int'(p) == DATA_W && bit_cnt[5] == !MONO;
    clr = rst || !en || state == IDLE;
  end
  always_comb begin
    state_n = state;
    if (!en)
      state_n = IDLE;
    else if (state == IDLE)
      state_n = SETTLE_FRAMES == 0 ? RUN : SETTLE;
    else if (state == SETTLE && wrap && int'(frame_cnt) + 1 >= SETTLE_FRAMES)
      state_n = RUN;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // pend delays the pair load by one clk so the last shifted bit is in shift_reg
  always_ff @(posedge clk) begin
    if (clr) begin
      div_cnt <= '0;
      bclk <= 1'b0;
      ws <= 1'b0;
      bit_cnt <= '0;
      frame_cnt <= '0;
      shift_reg <= '0;
      pend <= 1'b0;
      valid <= 1'b0;
      ovr <= 1'b0;
      if (rst) begin
        left_hold <= '0;
        pcm_l <= '0;
        pcm_r <= '0;
      end
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      bclk <= bclk ^ tick;
      if (fall) begin
        bit_cnt <= bit_nx;
        ws <= bit_nx[5];
      end
      if (wrap && state == SETTLE)
        frame_cnt <= frame_cnt + 1'b1;
      if (cap)
        shift_reg <= shifted;
      if (rise && int'(p) == DATA_W && !bit_cnt[5])
        left_hold <= shifted;
      pend <= last && state == RUN;
      if (pend) begin
        pcm_l <= MONO ? shift_reg : left_hold;
        pcm_r <= MONO ? '0 : shift_reg;
        valid <= 1'b1;
        ovr <= ovr || (valid && !bus.pcm_ready);
      end else if (bus.pcm_ready)
        valid <= 1'b0;
    end
  end
  assign bus.i2s_bclk = bclk;
  assign bus.i2s_ws = ws;
  assign bus.pcm_l = pcm_l;
  assign bus.pcm_r = pcm_r;
  assign bus.pcm_valid = valid;
  assign bus.overrun = ovr;
endmodule

// File: tb/tb_i2s_mic_rx.sv
// tb_i2s_mic_rx: I2S mic model driving a frame table; captured pairs checked through a scoreboard.
module tb_i2s_mic_rx;
  localparam int BCLK_DIV = 2;
  localparam int DATA_W = 24;
`ifdef MIC_MONO_EN
  localparam bit MONO = 1'b1;
  localparam int SF = 0;
`else
  localparam bit MONO = 1'b0;
  localparam int SF = 1;
`endif
  localparam int NV = 7;
  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic fill;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;
  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
  } pair_t;
  logic clk = 1'b0;
  logic rst;
  logic en;
  i2s_mic_rx_if #(.DATA_W(DATA_W)) bus ();
  i2s_mic_rx #(.BCLK_DIV(BCLK_DIV), .DATA_W(DATA_W), .SETTLE_FRAMES(SF)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int mic_bit = 0;
  int frame_idx = 0;
  int n_ev = 0;
  int n_pop = 0;
  int n_hi = 0;
  int t_brise = -1;
  int t_wrise = -1;
  bit did_bper = 0;
  bit did_wper = 0;
  bit did_whi = 0;
  bit sb_on = 0;
  bit exp_next = 0;
  logic pb = 1'b0;
  logic pws = 1'b0;
  logic prev_valid = 1'b0;
  vec_t cur;
  vec_t q_stim[$];
  pair_t q_exp[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask
  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask
  task automatic drive_sd();
    int p;
    logic [23:0] w;
    p = mic_bit % 32;
    w = mic_bit >= 32 ? cur.r : cur.l;
    bus.i2s_sd = (p >= 1 && p <= 24) ? w[24 - p] : cur.fill;
  endtask
  task automatic load_frame();
    pair_t e;
    if (q_stim.size() > 0) cur = q_stim.pop_front();
    else cur = '{24'h0, 24'h0, 1'b0, 24'h0, 24'h0};
    e.l = cur.el;
    e.r = MONO ? 24'h0 : cur.er;
    if (sb_on && frame_idx >= SF) q_exp.push_back(e);
  endtask
  task automatic start_mic();
    mic_bit = 0;
    frame_idx = 0;
    pb = 1'b0;
    load_frame();
    drive_sd();
  endtask
  task automatic tick();
    logic rdy;
    logic nv;
    logic rise;
    logic fall;
    pair_t e;
    rdy = bus.pcm_ready;
    @(posedge clk);
    #1;
    cyc++;
    nv = bus.pcm_valid && (!prev_valid || rdy);
    prev_valid = bus.pcm_valid;
    if (bus.pcm_valid) n_hi++;
    if (nv) n_ev++;
    if (sb_on && (nv || exp_next)) begin
      check("valid_timing", 32'(nv), 32'(exp_next));
      if (nv && q_exp.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: pcm_valid with no pair outstanding (cycle %0d)", cyc);
      end else if (nv) begin
        e = q_exp.pop_front();
        n_pop++;
        check("pcm_l", 32'(bus.pcm_l), 32'(e.l));
        check("pcm_r", 32'(bus.pcm_r), 32'(e.r));
      end
    end
    exp_next = 0;
    rise = !pb && bus.i2s_bclk;
    fall = pb && !bus.i2s_bclk;
    pb = bus.i2s_bclk;
    if (rise) begin
      if (t_brise >= 0 && !did_bper) begin
        check("bclk_period", cyc - t_brise, 2 * BCLK_DIV);
        did_bper = 1;
      end
      t_brise = cyc;
      if (sb_on && frame_idx >= SF && mic_bit == (MONO ? 24 : 56)) exp_next = 1;
    end
    if (bus.i2s_ws && !pws) begin
      if (t_wrise >= 0 && !did_wper) begin
        check("ws_period", cyc - t_wrise, 256);
        did_wper = 1;
      end
      t_wrise = cyc;
    end
    if (!bus.i2s_ws && pws && t_wrise >= 0 && !did_whi) begin
      check("ws_high", cyc - t_wrise, 128);
      did_whi = 1;
    end
    pws = bus.i2s_ws;
    if (fall) begin
      mic_bit = (mic_bit + 1) % 64;
      if (mic_bit == 0) begin
        frame_idx++;
        load_frame();
      end
    end
    drive_sd();
  endtask
  initial begin
    vec_t tbl[NV];
    int n;
    int b;
    int fi;
    int pop0;
    tbl[0] = '{24'hA5A5A5, 24'h5A5A5A, 1'b0, 24'hA5A5A5, 24'h5A5A5A};
    tbl[1] = '{24'h123456, 24'hFEDCBA, 1'b0, 24'h123456, 24'hFEDCBA};
    tbl[2] = '{24'h800000, 24'h7FFFFF, 1'b1, 24'h800000, 24'h7FFFFF};
    tbl[3] = '{24'hC0FFEE, 24'h000000, 1'b0, 24'hC0FFEE, 24'h000000};
    tbl[4] = '{24'hFFFFFF, 24'h000001, 1'b0, 24'hFFFFFF, 24'h000001};
    tbl[5] = '{24'h000000, 24'hFFFFFF, 1'b1, 24'h000000, 24'hFFFFFF};
    tbl[6] = '{24'h3C3C3C, 24'hC3C3C3, 1'b1, 24'h3C3C3C, 24'hC3C3C3};
    rst = 1'b1;
    en = 1'b1;
    bus.pcm_ready = 1'b1;
    bus.i2s_sd = 1'b1;
    cur = '{24'h0, 24'h0, 1'b1, 24'h0, 24'h0};
    repeat (3) tick();
    check("rst_bclk", 32'(bus.i2s_bclk), 0);
    check("rst_ws", 32'(bus.i2s_ws), 0);
    check("rst_pcm_l", 32'(bus.pcm_l), 0);
    check("rst_pcm_r", 32'(bus.pcm_r), 0);
    check("rst_valid", 32'(bus.pcm_valid), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    for (int i = 0; i < NV; i++) q_stim.push_back(tbl[i]);
    sb_on = 1;
    n_ev = 0;
    n_hi = 0;
    rst = 1'b0;
    start_mic();
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.i2s_bclk && n < 20);
    check("first_rise_tick", n, BCLK_DIV + 1);
    b = 0;
    while (frame_idx < 1 && b < 1000) begin
      tick();
      b++;
    end
    if (frame_idx < 1) timeout("frame0_end");
    check("frame0_events", n_ev, SF == 0 ? 1 : 0);
    for (int i = SF; i < NV; i++) begin
      b = 0;
      while (n_pop < i - SF + 1 && b < 2000) begin
        tick();
        b++;
      end
      if (n_pop < i - SF + 1) timeout("vector_capture");
    end
    check("valid_one_clk", n_hi, NV - SF);
    check("overrun_ready", 32'(bus.overrun), 0);
    sb_on = 0;
    q_exp.delete();
    bus.pcm_ready = 1'b0;
    fi = frame_idx;
    q_stim.push_back('{24'h111111, 24'h222222, 1'b0, 24'h111111, 24'h222222});
    q_stim.push_back('{24'h333333, 24'h444444, 1'b0, 24'h333333, 24'h444444});
    b = 0;
    while (frame_idx < fi + 3 && b < 3000) begin
      tick();
      b++;
    end
    if (frame_idx < fi + 3) timeout("overrun_frames");
    repeat (2) tick();
    check("ovr_valid", 32'(bus.pcm_valid), 1);
    check("ovr_flag", 32'(bus.overrun), 1);
    check("ovr_pcm_l", 32'(bus.pcm_l), 32'h333333);
    check("ovr_pcm_r", 32'(bus.pcm_r), MONO ? 32'h0 : 32'h444444);
    bus.pcm_ready = 1'b1;
    tick();
    check("ovr_accept_valid", 32'(bus.pcm_valid), 0);
    check("ovr_sticky", 32'(bus.overrun), 1);
    b = 0;
    while (mic_bit != 10 && b < 1000) begin
      tick();
      b++;
    end
    if (mic_bit != 10) timeout("left_bit10");
    en = 1'b0;
    tick();
    check("en0_bclk", 32'(bus.i2s_bclk), 0);
    check("en0_ws", 32'(bus.i2s_ws), 0);
    check("en0_valid", 32'(bus.pcm_valid), 0);
    check("en0_overrun", 32'(bus.overrun), 0);
    check("en0_pcm_l_hold", 32'(bus.pcm_l), 32'h333333);
    repeat (10) tick();
    check("idle_bclk", 32'(bus.i2s_bclk), 0);
    q_exp.delete();
    q_stim.push_back('{24'hDEADBE, 24'hEF0123, 1'b0, 24'hDEADBE, 24'hEF0123});
    q_stim.push_back('{24'h654321, 24'h0ABCDE, 1'b1, 24'h654321, 24'h0ABCDE});
    sb_on = 1;
    pop0 = n_pop;
    en = 1'b1;
    start_mic();
    b = 0;
    while (n_pop < pop0 + 2 - SF && b < 3000) begin
      tick();
      b++;
    end
    if (n_pop < pop0 + 2 - SF) timeout("restart_capture");
    check("restart_overrun", 32'(bus.overrun), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
